// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_sb                                                    |
// | Desc     : Register file with pending-write scoreboard and IO status reg |
// |            at address REGNUM-1. Optional bypass: REGFILE_BYPASS_EN.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module regfile_sb #(
   parameter int WIDTH        = 16,
   parameter int REGNUM       = 16,
   parameter int ADDRESSWIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    startIO,
   input  logic                    we3,
   input  logic [ADDRESSWIDTH-1:0] wa3,
   input  logic [WIDTH-1:0]        wd3,
   input  logic [ADDRESSWIDTH-1:0] ra1,
   input  logic [ADDRESSWIDTH-1:0] ra2,
   input  logic                    issue,
   input  logic [ADDRESSWIDTH-1:0] issue_rd,
   output logic [WIDTH-1:0]        rd1,
   output logic [WIDTH-1:0]        rd2,
   output logic                    busy1,
   output logic                    busy2
);

   localparam int                      NDATA     = REGNUM - 1;
   localparam logic [ADDRESSWIDTH-1:0] c_IO_ADDR = ADDRESSWIDTH'(REGNUM - 1);

   logic [WIDTH-1:0] r_rf [NDATA];
   logic [NDATA-1:0] r_busy;
   logic             r_s1;
   logic             r_s2;
   logic             r_s2_d;
   logic             r_io_edge;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NDATA; i++) begin
            r_rf[i] <= '0;
         end
         r_busy    <= '0;
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_s2_d    <= 1'b0;
         r_io_edge <= 1'b0;
      end else begin
         r_s1   <= startIO;
         r_s2   <= r_s1;
         r_s2_d <= r_s2;
         // Edge detection is ordered last so a coincident clear loses.
         if (we3 && (wa3 == c_IO_ADDR) && wd3[1]) begin
            r_io_edge <= 1'b0;
         end
         if (r_s2 && !r_s2_d) begin
            r_io_edge <= 1'b1;
         end
         for (int i = 0; i < NDATA; i++) begin
            if (we3 && (wa3 == ADDRESSWIDTH'(i))) begin
               r_rf[i]   <= wd3;
               r_busy[i] <= 1'b0;
            end
            // A same-cycle issue overrides the writeback clear: new producer wins.
            if (issue && (issue_rd == ADDRESSWIDTH'(i))) begin
               r_busy[i] <= 1'b1;
            end
         end
      end
   end

   // Returns {busy, data} for one read port.
   function automatic logic [WIDTH:0] f_read(input logic [ADDRESSWIDTH-1:0] a);
      logic [WIDTH-1:0] w_data;
      logic             w_busy;
      w_data = '0;
      w_busy = 1'b0;
      if (a == c_IO_ADDR) begin
         w_data = {{(WIDTH-2){1'b0}}, r_io_edge, r_s2};
      end else begin
         for (int i = 0; i < NDATA; i++) begin
            if (a == ADDRESSWIDTH'(i)) begin
               w_data = r_rf[i];
               w_busy = r_busy[i];
`ifdef REGFILE_BYPASS_EN
               if (we3 && (wa3 == a)) begin
                  w_data = wd3;
                  w_busy = 1'b0;
               end
`endif
            end
         end
      end
      return {w_busy, w_data};
   endfunction

   always_comb begin
      {busy1, rd1} = f_read(ra1);
   end

   always_comb begin
      {busy2, rd2} = f_read(ra2);
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_sb                                                 |
// | Desc     : Directed + random bench for regfile_sb against a behavioural  |
// |            model. Follows REGFILE_BYPASS_EN like the design.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_regfile_sb;

   localparam int IOA = 15;

   logic        clk = 1'b0;
   logic        rst_n, startIO, we3, issue;
   logic [3:0]  wa3, ra1, ra2, issue_rd;
   logic [15:0] wd3, rd1, rd2;
   logic        busy1, busy2;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural state: m_sync = {s2_d, s2, s1} as startIO samples 3/2/1 edges ago.
   logic [15:0] m_rf [16];
   logic        m_busy [16];
   logic [2:0]  m_sync;
   logic        m_edge;

   regfile_sb #(.WIDTH(16), .REGNUM(16), .ADDRESSWIDTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .startIO(startIO), .we3(we3), .wa3(wa3),
      .wd3(wd3), .ra1(ra1), .ra2(ra2), .issue(issue), .issue_rd(issue_rd),
      .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] model_read(input logic [3:0] a);
      if (int'(a) == IOA) return {1'b0, 14'd0, m_edge, m_sync[1]};
`ifdef REGFILE_BYPASS_EN
      if (we3 && wa3 == a) return {1'b0, wd3};
`endif
      return {m_busy[a], m_rf[a]};
   endfunction

   task automatic model_update();
      logic new_edge;
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            m_rf[i]   = 16'h0;
            m_busy[i] = 1'b0;
         end
         m_sync = 3'b000;
         m_edge = 1'b0;
      end else begin
         new_edge = m_edge;
         if (we3 && int'(wa3) == IOA && wd3[1]) new_edge = 1'b0;
         if (m_sync[1] && !m_sync[2]) new_edge = 1'b1;
         m_edge = new_edge;
         m_sync = {m_sync[1:0], startIO};
         if (we3 && int'(wa3) < IOA) begin
            m_rf[wa3]   = wd3;
            m_busy[wa3] = 1'b0;
         end
         if (issue && int'(issue_rd) < IOA) m_busy[issue_rd] = 1'b1;
      end
   endtask

   // Inputs are set at a negedge; outputs checked 1ns later, model advanced at posedge.
   task automatic tick(input bit do_check);
      logic [16:0] e1, e2;
      #1;
      if (do_check) begin
         e1 = model_read(ra1);
         e2 = model_read(ra2);
         chk("rd1", rd1, e1[15:0]);
         chk("busy1", busy1, e1[16]);
         chk("rd2", rd2, e2[15:0]);
         chk("busy2", busy2, e2[16]);
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      rst_n = 1'b1; we3 = 1'b0; issue = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; startIO = 1'b0; we3 = 1'b0; issue = 1'b0;
      wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0; issue_rd = '0;
      tick(0);

      // Reset discards data, busy and ignores same-cycle write/issue
      idle(); we3 = 1'b1; wa3 = 4'd3; wd3 = 16'h1234; ra1 = 4'd3; ra2 = 4'd0; tick(1);
      idle(); ra1 = 4'd3; #1; chk("pre_rst_r3", rd1, 16'h1234); tick(1);
      rst_n = 1'b0; we3 = 1'b1; wa3 = 4'd3; wd3 = 16'hFFFF; issue = 1'b1; issue_rd = 4'd4; tick(1);
      idle(); ra1 = 4'd3; ra2 = 4'd15; #1;
      chk("rst_r3", rd1, 16'h0); chk("rst_io", rd2, 16'h0); chk("rst_busy", busy1, 1'b0);
      tick(1);
      idle(); ra1 = 4'd4; #1; chk("rst_issue_ign", busy1, 1'b0); tick(1);

      // Scoreboard
      idle(); issue = 1'b1; issue_rd = 4'd5; ra1 = 4'd5; tick(1);
      idle(); ra1 = 4'd5; #1; chk("sb_busy_set", busy1, 1'b1);
      we3 = 1'b1; wa3 = 4'd5; wd3 = 16'hBEEF; tick(1);
      idle(); ra1 = 4'd5; #1; chk("sb_busy_clr", busy1, 1'b0); chk("sb_data", rd1, 16'hBEEF); tick(1);

      // Same-cycle issue and write: data written, busy stays set
      idle(); issue = 1'b1; issue_rd = 4'd2; we3 = 1'b1; wa3 = 4'd2; wd3 = 16'h0042; ra1 = 4'd2; tick(1);
      idle(); ra1 = 4'd2; #1; chk("sim_data", rd1, 16'h0042); chk("sim_busy", busy1, 1'b1); tick(1);

      // Bypass behaviour with busy pending
      idle(); we3 = 1'b1; wa3 = 4'd7; wd3 = 16'h1111; tick(1);
      idle(); issue = 1'b1; issue_rd = 4'd7; tick(1);
      idle(); we3 = 1'b1; wa3 = 4'd7; wd3 = 16'hA5A5; ra2 = 4'd7; #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_data", rd2, 16'hA5A5); chk("byp_busy", busy2, 1'b0);
`else
      chk("nobyp_data", rd2, 16'h1111); chk("nobyp_busy", busy2, 1'b1);
`endif
      tick(1);

      // IO synchroniser and edge latch
      idle(); ra1 = 4'd15; startIO = 1'b1; tick(1);
      tick(1);
      #1; chk("io_s2", rd1, 16'h0001); tick(1);
      #1; chk("io_edge", rd1, 16'h0003);
      we3 = 1'b1; wa3 = 4'd15; wd3 = 16'h0002; tick(1);
      idle(); #1; chk("io_clear", rd1, 16'h0001);
      startIO = 1'b0; tick(1); tick(1); tick(1);
      #1; chk("io_low", rd1, 16'h0000);
      startIO = 1'b1; tick(1); tick(1);
      we3 = 1'b1; wa3 = 4'd15; wd3 = 16'h0002; tick(1);
      idle(); #1; chk("io_race", rd1, 16'h0003); tick(1);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         rst_n    = ($urandom_range(0, 49) != 0);
         we3      = $urandom_range(0, 1);
         issue    = ($urandom_range(0, 9) < 4);
         wa3      = 4'($urandom_range(0, 15));
         issue_rd = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
         wd3      = 16'($urandom);
         ra1      = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
         ra2      = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) startIO = ~startIO;
         tick(1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
